alu_op_sequencer: RTL



---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_result_mux.sv | 38 +++
 rtl/alu_op_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and helpers for the ALU op sequencer
//
// Holds the opcode and FSM state enums plus the sign-magnitude widening
// helper used by the result mux.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } seq_state_e;

  // Widen an n-bit sign-magnitude value to 2n bits: the sign moves to bit
  // 2n-1 and the magnitude is zero-extended. Works on a 64-bit carrier so it
  // serves any n up to 32; callers truncate the return to 2n bits.
  function automatic logic [63:0] sm_widen(input logic [63:0] r, input int n);
    logic [63:0] mag_mask;
    logic [63:0] sign;
    mag_mask = (64'd1 << (n - 1)) - 64'd1;
    sign     = (r >> (n - 1)) & 64'd1;
    return (r & mag_mask) | (sign << (2 * n - 1));
  endfunction

endpackage

// File: rtl/alu_result_mux.sv
// rtl/alu_result_mux.sv - opcode to 2N-bit result select
//
// Purely combinational. Picks the datapath output matching the latched
// opcode and widens N-bit results to 2N bits; MUL passes through unchanged.
// Illegal opcodes select zero.
//
// Ports:
//   op_i                          latched opcode
//   sum_i, sub_i, div_i, mod_i    N-bit sign-magnitude datapath results
//   mult_i                        2N-bit sign-magnitude product
//   result_o                      2N-bit selected result
module alu_result_mux
  import alu_seq_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [2:0]     op_i,
  input  logic [N-1:0]   sum_i,
  input  logic [N-1:0]   sub_i,
  input  logic [2*N-1:0] mult_i,
  input  logic [N-1:0]   div_i,
  input  logic [N-1:0]   mod_i,
  output logic [2*N-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = (2*N)'(sm_widen(64'(sum_i), N));
      OP_SUB:  result_o = (2*N)'(sm_widen(64'(sub_i), N));
      OP_MUL:  result_o = mult_i;
      OP_DIV:  result_o = (2*N)'(sm_widen(64'(div_i), N));
      OP_MOD:  result_o = (2*N)'(sm_widen(64'(mod_i), N));
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response sequencer for the shared ALU datapath
//
// Accepts one request, registers operands onto alu_a/alu_b, waits an
// op-dependent settle time, captures the selected result and presents it
// with error flags until the consumer takes it.
// Optional macro ALU_OP_STATS_EN adds a 16-bit response counter op_count.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake
//   req_op, req_a, req_b           opcode and sign-magnitude operands
//   alu_a, alu_b                   registered operands to the datapath
//   alu_sum/sub/mult/div/mod       datapath results
//   rsp_valid/rsp_ready            response handshake
//   rsp_result                     2N-bit sign-magnitude result
//   rsp_err_divzero, rsp_err_op    error flags
//   busy                           high whenever not IDLE
//   op_count                       (ALU_OP_STATS_EN) response count, wraps
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N           = 6,
  parameter int FAST_SETTLE = 1,
  parameter int SLOW_SETTLE = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2:0]     req_op,
  input  logic [N-1:0]   req_a,
  input  logic [N-1:0]   req_b,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [N-1:0]   alu_sum,
  input  logic [N-1:0]   alu_sub,
  input  logic [2*N-1:0] alu_mult,
  input  logic [N-1:0]   alu_div,
  input  logic [N-1:0]   alu_mod,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_result,
  output logic           rsp_err_divzero,
  output logic           rsp_err_op,
  output logic           busy
`ifdef ALU_OP_STATS_EN
  ,
  output logic [15:0]    op_count
`endif
);

  localparam int MAX_SETTLE = (FAST_SETTLE > SLOW_SETTLE) ? FAST_SETTLE : SLOW_SETTLE;
  localparam int CNT_W      = $clog2(MAX_SETTLE + 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [N-1:0]     alu_a_q, alu_a_d;
  logic [N-1:0]     alu_b_q, alu_b_d;
  logic [2*N-1:0]   result_q, result_d;
  logic             err_dz_q, err_dz_d;
  logic             err_op_q, err_op_d;
  logic [2*N-1:0]   mux_result;

  alu_result_mux #(.N(N)) u_result_mux (
    .op_i     (op_q),
    .sum_i    (alu_sum),
    .sub_i    (alu_sub),
    .mult_i   (alu_mult),
    .div_i    (alu_div),
    .mod_i    (alu_mod),
    .result_o (mux_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    result_d  = result_q;
    err_dz_d  = err_dz_q;
    err_op_d  = err_op_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          op_d     = req_op;
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          result_d = '0;
          err_dz_d = 1'b0;
          err_op_d = 1'b0;
          if (req_op > OP_MOD) begin
            err_op_d = 1'b1;
            state_d  = RESP;
          end else if ((req_op == OP_DIV || req_op == OP_MOD) && req_b[N-2:0] == '0) begin
            // Both +0 and -0 divisors short-circuit; the datapath is not waited on.
            err_dz_d = 1'b1;
            state_d  = RESP;
          end else begin
            state_d = SETTLE;
            cnt_d   = (req_op == OP_ADD || req_op == OP_SUB) ? CNT_W'(FAST_SETTLE - 1)
                                                             : CNT_W'(SLOW_SETTLE - 1);
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          result_d = mux_result;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        // A new request is never taken here; IDLE always separates responses.
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      err_dz_q <= 1'b0;
      err_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      result_q <= result_d;
      err_dz_q <= err_dz_d;
      err_op_q <= err_op_d;
    end
  end

  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign rsp_result      = result_q;
  assign rsp_err_divzero = err_dz_q;
  assign rsp_err_op      = err_op_q;

`ifdef ALU_OP_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  // Counts every response handshake, error responses included; wraps naturally.
  always_comb begin
    op_count_d = op_count_q;
    if (state_q == RESP && rsp_ready) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

endmodule
